hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage DLX pipeline (IF/ID/EX/MEM/WB).
- Sits beside the decode stage. Takes the decoded register-use fields of the instruction in ID and tracks what is in flight:
  - the instruction in EX;
  - one outstanding multi-cycle FPU operation (MULT/DIV family).
- Generates the PC/IF-ID hold, the EX bubble insertion and the branch flush.
- Forwarding from MEM/WB is handled in the datapath. This block resolves only load-use, long-FPU RAW/WAW and FPU structural hazards.

---
 rtl/hazard_stall_ctrl_pkg.sv | 51 +++++
 rtl/hazard_stall_ctrl_if.sv | 41 ++++
 rtl/hazard_stall_ctrl_reg_match.sv | 15 +
 rtl/hazard_stall_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the DLX decode-stage sequencing controller and the
// decoder that feeds it.
package hazard_stall_ctrl_pkg;

  localparam int REG_W = 5;
  typedef logic [0:REG_W-1] reg_id_t;

  // Encoding loaded into a pipeline register to make it a bubble.
  localparam logic [0:31] NOP_INSN = 32'h5400_0000;

  // Writeback data source selected by the decoder; DIN_MEM marks a load.
  typedef enum logic [1:0] {
    DIN_ALU = 2'b00,
    DIN_PC  = 2'b01,
    DIN_FPU = 2'b10,
    DIN_MEM = 2'b11
  } din_src_e;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'b00,
    JMP_BEQZ   = 2'b01,
    JMP_BNEZ   = 2'b10,
    JMP_UNCOND = 2'b11
  } jump_type_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7,
    ALU_SLT = 4'h8,
    ALU_SEQ = 4'h9
  } alu_op_e;

  localparam int FPU_LAT_DEF = 5;
  localparam int CNT_W_DEF   = 4;

  // What the controller remembers about the instruction now in EX.
  typedef struct packed {
    logic    valid;
    reg_id_t dest;
    logic    fp;
    logic    regwe;
    logic    load;
  } ex_slot_t;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage register-use fields in, pipeline sequencing controls out.
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  logic    id_valid;
  reg_id_t id_rs1;
  logic    id_rs1_fp;
  logic    id_rs1_used;
  reg_id_t id_rs2;
  logic    id_rs2_fp;
  logic    id_rs2_used;
  reg_id_t id_dest;
  logic    id_dest_fp;
  logic    id_regwe;
  logic    id_load;
  logic    id_long;
  logic    ex_branch_taken;

  logic    stall;
  logic    bubble_ex;
  logic    flush_id;
  logic    fpu_busy;
  logic    fpu_done;

  // Decoder / pipeline side.
  modport master (
    output id_valid, id_rs1, id_rs1_fp, id_rs1_used, id_rs2, id_rs2_fp,
           id_rs2_used, id_dest, id_dest_fp, id_regwe, id_load, id_long,
           ex_branch_taken,
    input  stall, bubble_ex, flush_id, fpu_busy, fpu_done
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs1_fp, id_rs1_used, id_rs2, id_rs2_fp,
           id_rs2_used, id_dest, id_dest_fp, id_regwe, id_load, id_long,
           ex_branch_taken,
    output stall, bubble_ex, flush_id, fpu_busy, fpu_done
  );

endinterface

// File: rtl/hazard_stall_ctrl_reg_match.sv
// Register-identity comparator: same number and same file (GPR/FPR).
// GPR R0 is hardwired to zero and never carries a dependency; F0 does.
module hazard_stall_ctrl_reg_match
  import hazard_stall_ctrl_pkg::*;
(
  input  reg_id_t r,
  input  logic    fp,
  input  reg_id_t d,
  input  logic    dfp,
  output logic    match
);

  assign match = (r == d) && (fp == dfp) && !(!fp && (r == '0));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use, long-FPU RAW/WAW and FPU structural hazard detection for the
// 5-stage DLX pipeline, plus branch flush. MEM/WB forwarding lives in the
// datapath, so only the cases forwarding cannot cover are stalled here.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int FPU_LAT = FPU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
);

  ex_slot_t         ex_q;
  logic [CNT_W-1:0] lo_cnt;
  reg_id_t          lo_dest;
  logic             lo_fp;

  logic rs1_ex, rs2_ex, rs1_lo, rs2_lo, dest_lo;
  // Single-cycle writes retire in order, so ID-vs-EX destination overlap is
  // never a hazard; the comparison is kept only for the symmetric layout.
  logic dest_ex_unused;

  logic load_use, lo_active, long_hz, hz, issue;

  hazard_stall_ctrl_reg_match u_rs1_ex (.r(bus.id_rs1), .fp(bus.id_rs1_fp),
    .d(ex_q.dest), .dfp(ex_q.fp), .match(rs1_ex));
  hazard_stall_ctrl_reg_match u_rs2_ex (.r(bus.id_rs2), .fp(bus.id_rs2_fp),
    .d(ex_q.dest), .dfp(ex_q.fp), .match(rs2_ex));
  hazard_stall_ctrl_reg_match u_dest_ex (.r(bus.id_dest), .fp(bus.id_dest_fp),
    .d(ex_q.dest), .dfp(ex_q.fp), .match(dest_ex_unused));
  hazard_stall_ctrl_reg_match u_rs1_lo (.r(bus.id_rs1), .fp(bus.id_rs1_fp),
    .d(lo_dest), .dfp(lo_fp), .match(rs1_lo));
  hazard_stall_ctrl_reg_match u_rs2_lo (.r(bus.id_rs2), .fp(bus.id_rs2_fp),
    .d(lo_dest), .dfp(lo_fp), .match(rs2_lo));
  hazard_stall_ctrl_reg_match u_dest_lo (.r(bus.id_dest), .fp(bus.id_dest_fp),
    .d(lo_dest), .dfp(lo_fp), .match(dest_lo));

  // Hazard detection and the stall / bubble / flush controls.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_use      = 1'b0;
    long_hz       = 1'b0;
    lo_active     = (lo_cnt != '0);
    hz            = 1'b0;
    issue         = 1'b0;
    bus.stall     = 1'b0;
    bus.bubble_ex = 1'b0;
    bus.flush_id  = 1'b0;

    load_use = ex_q.valid && ex_q.load && ex_q.regwe &&
               ((bus.id_rs1_used && rs1_ex) || (bus.id_rs2_used && rs2_ex));
    long_hz  = lo_active &&
               (bus.id_long ||
                (bus.id_rs1_used && rs1_lo) || (bus.id_rs2_used && rs2_lo) ||
                (bus.id_regwe && dest_lo));
    hz       = bus.id_valid && (load_use || long_hz);

    // A taken branch kills ID, so it overrides any hazard stall.
    bus.stall     = hz && !bus.ex_branch_taken;
    bus.flush_id  = bus.ex_branch_taken;
    bus.bubble_ex = hz || bus.ex_branch_taken;
    issue         = bus.id_valid && !bus.stall && !bus.ex_branch_taken;
  end

  // EX tracker and long-op occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: asynchronous reset clears the counter, so an in-flight long op is dropped with no fpu_done.
    if (reset) begin
      ex_q         <= '0;
      lo_cnt       <= '0;
      lo_dest      <= '0;
      lo_fp        <= 1'b0;
      bus.fpu_busy <= 1'b0;
      bus.fpu_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ex_q.valid   <= issue;
      bus.fpu_done <= 1'b0;
      if (issue) begin
        ex_q.dest  <= bus.id_dest;
        ex_q.fp    <= bus.id_dest_fp;
        ex_q.regwe <= bus.id_regwe;
        ex_q.load  <= bus.id_load;
      end

      if (issue && bus.id_long) begin
        lo_cnt       <= CNT_W'(FPU_LAT - 1);
        lo_dest      <= bus.id_dest;
        lo_fp        <= bus.id_dest_fp;
        bus.fpu_busy <= 1'b1;
      end else if (lo_cnt != '0) begin
        lo_cnt <= lo_cnt - CNT_W'(1);
        if (lo_cnt == CNT_W'(1)) begin
          bus.fpu_busy <= 1'b0;
          bus.fpu_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scenario bench for hazard_stall_ctrl. Each cycle's expected control vector
// {stall, bubble_ex, flush_id, fpu_busy, fpu_done} is queued as the stimulus
// is driven; the observed vector is sampled at the falling edge.
module tb_hazard_stall_ctrl;

  localparam int FPU_LAT = 5;

  localparam logic [4:0] E_IDLE   = 5'b00000;
  localparam logic [4:0] E_STALL  = 5'b11000;
  localparam logic [4:0] E_FLUSH  = 5'b01100;
  localparam logic [4:0] E_BUSY   = 5'b00010;
  localparam logic [4:0] E_BSTALL = 5'b11010;
  localparam logic [4:0] E_BFLUSH = 5'b01110;
  localparam logic [4:0] E_DONE   = 5'b00001;

  typedef struct {
    string      name;
    logic [4:0] v;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  exp_t       exp_q[$];
  logic [4:0] obs_q[$];

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.FPU_LAT(FPU_LAT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  task automatic set_id(input logic v,
                        input logic [4:0] rs1, input logic f1, input logic u1,
                        input logic [4:0] rs2, input logic f2, input logic u2,
                        input logic [4:0] d, input logic dfp, input logic we,
                        input logic ld, input logic lng);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs1_fp   = f1;
    bus.id_rs1_used = u1;
    bus.id_rs2      = rs2;
    bus.id_rs2_fp   = f2;
    bus.id_rs2_used = u2;
    bus.id_dest     = d;
    bus.id_dest_fp  = dfp;
    bus.id_regwe    = we;
    bus.id_load     = ld;
    bus.id_long     = lng;
  endtask

  task automatic id_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One pipeline cycle: queue expectation, sample at negedge, advance past posedge.
  task automatic tick(input string name, input logic [4:0] e);
    exp_q.push_back('{name, e});
    @(negedge clk);
    obs_q.push_back({bus.stall, bus.bubble_ex, bus.flush_id, bus.fpu_busy, bus.fpu_done});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e; logic [4:0] o;
    reset = 1'b1;
    bus.ex_branch_taken = 1'b0;
    id_idle();
    #2;
    tick("reset_state", E_IDLE);
    reset = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, o, e.v); end
    end
  endtask

  task automatic test_load_use();
    exp_t e; logic [4:0] o;
    set_id(1, 1, 0, 1, 0, 0, 0, 3, 0, 1, 1, 0); tick("lw_r3", E_IDLE);
    set_id(1, 3, 0, 1, 5, 0, 1, 4, 0, 1, 0, 0); tick("lu_rs1_stall", E_STALL);
    tick("lu_rs1_release", E_IDLE);
    set_id(1, 1, 0, 1, 0, 0, 0, 3, 0, 1, 1, 0); tick("lw_r3_b", E_IDLE);
    set_id(1, 5, 0, 1, 3, 0, 1, 4, 0, 1, 0, 0); tick("lu_rs2_stall", E_STALL);
    tick("lu_rs2_release", E_IDLE);
    set_id(1, 1, 0, 1, 0, 0, 0, 3, 0, 1, 1, 0); tick("lw_r3_c", E_IDLE);
    set_id(1, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0); tick("lu_unused_src", E_IDLE);
    set_id(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0); tick("lw_r0", E_IDLE);
    set_id(1, 0, 0, 1, 5, 0, 1, 4, 0, 1, 0, 0); tick("lu_r0_no_stall", E_IDLE);
    id_idle(); tick("lu_idle", E_IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, o, e.v); end
    end
  endtask

  task automatic test_gpr_fpr();
    exp_t e; logic [4:0] o;
    set_id(1, 1, 0, 1, 0, 0, 0, 2, 0, 1, 1, 0); tick("lw_r2", E_IDLE);
    set_id(1, 2, 1, 1, 1, 1, 1, 3, 1, 1, 0, 0); tick("addf_f2_after_lw_r2", E_IDLE);
    set_id(1, 1, 0, 1, 0, 0, 0, 2, 1, 1, 1, 0); tick("lf_f2", E_IDLE);
    set_id(1, 2, 1, 1, 1, 1, 1, 5, 1, 1, 0, 0); tick("addf_f2_stall", E_STALL);
    tick("addf_f2_release", E_IDLE);
    set_id(1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0); tick("lf_f0", E_IDLE);
    set_id(1, 0, 1, 1, 1, 1, 1, 5, 1, 1, 0, 0); tick("f0_stall", E_STALL);
    tick("f0_release", E_IDLE);
    id_idle(); tick("fp_idle", E_IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, o, e.v); end
    end
  endtask

  task automatic test_long_raw();
    exp_t e; logic [4:0] o;
    set_id(1, 1, 1, 1, 2, 1, 1, 4, 1, 1, 0, 1); tick("multf_issue", E_IDLE);
    set_id(1, 4, 1, 1, 1, 1, 1, 6, 1, 1, 0, 0);
    for (int i = 0; i < FPU_LAT - 1; i++) tick($sformatf("raw_stall_%0d", i), E_BSTALL);
    tick("raw_done_issue", E_DONE);
    id_idle(); tick("raw_done_once", E_IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, o, e.v); end
    end
  endtask

  task automatic test_struct_waw();
    exp_t e; logic [4:0] o;
    set_id(1, 1, 1, 1, 2, 1, 1, 4, 1, 1, 0, 1); tick("multf_f4", E_IDLE);
    set_id(1, 1, 1, 1, 0, 0, 0, 4, 1, 1, 0, 0); tick("movf_f4_waw", E_BSTALL);
    set_id(1, 1, 0, 1, 2, 0, 1, 4, 0, 1, 0, 0); tick("add_r4_free", E_BUSY);
    set_id(1, 1, 1, 1, 2, 1, 1, 8, 1, 1, 0, 1);
    tick("divf_struct_c2", E_BSTALL);
    tick("divf_struct_c1", E_BSTALL);
    tick("divf_issue_at_zero", E_DONE);
    id_idle();
    for (int i = 0; i < FPU_LAT - 1; i++) tick($sformatf("divf_busy_%0d", i), E_BUSY);
    tick("divf_done", E_DONE);
    tick("divf_idle", E_IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, o, e.v); end
    end
  endtask

  task automatic test_branch();
    exp_t e; logic [4:0] o;
    set_id(1, 1, 0, 1, 0, 0, 0, 3, 0, 1, 1, 0); tick("br_lw_r3", E_IDLE);
    set_id(1, 3, 0, 1, 5, 0, 1, 4, 0, 1, 0, 0);
    bus.ex_branch_taken = 1'b1; tick("br_beats_loaduse", E_FLUSH);
    bus.ex_branch_taken = 1'b0; tick("br_ex_cleared", E_IDLE);
    set_id(1, 1, 1, 1, 2, 1, 1, 4, 1, 1, 0, 1);
    bus.ex_branch_taken = 1'b1; tick("br_kills_long", E_FLUSH);
    bus.ex_branch_taken = 1'b0;
    set_id(1, 4, 1, 1, 1, 1, 1, 6, 1, 1, 0, 0); tick("br_no_long_issued", E_IDLE);
    set_id(1, 1, 1, 1, 2, 1, 1, 4, 1, 1, 0, 1); tick("br_multf", E_IDLE);
    id_idle();
    bus.ex_branch_taken = 1'b1; tick("br_keeps_long", E_BFLUSH);
    bus.ex_branch_taken = 1'b0;
    for (int i = 0; i < FPU_LAT - 2; i++) tick($sformatf("br_busy_%0d", i), E_BUSY);
    tick("br_long_done", E_DONE);
    tick("br_idle", E_IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, o, e.v); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [4:0] o;
    set_id(1, 1, 1, 1, 2, 1, 1, 4, 1, 1, 0, 1); tick("rm_multf", E_IDLE);
    id_idle(); tick("rm_busy", E_BUSY);
    set_id(1, 4, 1, 1, 1, 1, 1, 6, 1, 1, 0, 0);
    reset = 1'b1; tick("rm_reset_clears", E_IDLE);
    reset = 1'b0; tick("rm_dep_after_reset", E_IDLE);
    id_idle();
    for (int i = 0; i < FPU_LAT; i++) tick($sformatf("rm_no_done_%0d", i), E_IDLE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.v) begin errors++; $display("FAIL %s: got %b want %b", e.name, o, e.v); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_gpr_fpr();
    test_long_raw();
    test_struct_waw();
    test_branch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
